// File: rtl/counter_pkg.sv
// Shared types and constants for the parameterised up/down counter.
// Provides the boundary mode enum, width limits and prescaler sizing helper.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_MAX_WIDTH = 32;
    localparam int PSC_MAX       = 256;

    // Bits needed to hold 0..p-1, never less than one.
    function automatic int psc_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/param_counter_if.sv
// Bundle of the counter's control and status signals.
// master: drives enable/up_dn/load/load_val, observes cnt/tc/ovf; slave: the reverse.
interface param_counter_if #(
    parameter int WIDTH = 8
) (
    input logic clk
);

    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             ovf;

    modport master (
        input  clk,
        output enable, up_dn, load, load_val,
        input  cnt, tc, ovf
    );

    modport slave (
        input  clk,
        input  enable, up_dn, load, load_val,
        output cnt, tc, ovf
    );

endinterface

// File: rtl/cnt_prescaler.sv
// Divides enabled cycles by PRESCALE and flags the cycle on which a count step occurs.
// Ports: clk, reset (async high), enable (advance), clr (sync clear), step (comb. strobe).
module cnt_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic step
);

    localparam int            PW   = psc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q;
    logic [PW-1:0] psc_d;
    logic          at_last;

    assign at_last = (psc_q == LAST);

    // A clear (load) always beats a step on the same edge.
    assign step = enable & ~clr & at_last;

    always_comb begin
        psc_d = psc_q;
        if (clr) begin
            psc_d = '0;
        end else if (enable) begin
            psc_d = at_last ? '0 : psc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Prescaled up/down counter with wrap or saturate boundary, load, tc pulse and sticky ovf.
// Ports: clk, reset (async high), enable, up_dn, load, load_val -> cnt, tc, ovf (registered).
module param_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter cnt_mode_e       MODE     = MODE_WRAP,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "param_counter: WIDTH %0d outside 2..32", WIDTH);
    end

    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $fatal(1, "param_counter: MAX_VAL %0d illegal", MAX_VAL);
    end

    if (PRESCALE < 1 || PRESCALE > PSC_MAX) begin : g_bad_psc
        $fatal(1, "param_counter: PRESCALE %0d outside 1..256", PRESCALE);
    end

    localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
    localparam logic             SAT  = (MODE == MODE_SAT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step;

    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_psc (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (load),
        .step   (step)
    );

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (load) begin
            cnt_d = (load_val > MAXV) ? MAXV : load_val;
            ovf_d = 1'b0;
        end else if (step) begin
            if (up_dn) begin
                if (cnt_q == MAXV) begin
                    cnt_d = SAT ? MAXV : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = SAT ? '0 : MAXV;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: three configurations share one stimulus stream.
// Expected states come from an arithmetic model and are queued for a separate monitor.
module tb_param_counter;
    import counter_pkg::*;

    typedef struct {
        int cnt;
        int psc;
        bit tc;
        bit ovf;
    } mst_t;

    logic clk;
    logic reset;

    int tests  = 0;
    int errors = 0;

    mst_t ma, mb, mc, zero_st;
    mst_t qa[$];
    mst_t qb[$];
    mst_t qc[$];

    param_counter_if #(.WIDTH(8)) if_a (.clk(clk));
    param_counter_if #(.WIDTH(4)) if_b (.clk(clk));
    param_counter_if #(.WIDTH(4)) if_c (.clk(clk));

    param_counter #(
        .WIDTH(8), .MAX_VAL(255), .MODE(MODE_WRAP), .PRESCALE(1)
    ) u_a (
        .clk(clk), .reset(reset),
        .enable(if_a.enable), .up_dn(if_a.up_dn),
        .load(if_a.load), .load_val(if_a.load_val),
        .cnt(if_a.cnt), .tc(if_a.tc), .ovf(if_a.ovf)
    );

    param_counter #(
        .WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(3)
    ) u_b (
        .clk(clk), .reset(reset),
        .enable(if_b.enable), .up_dn(if_b.up_dn),
        .load(if_b.load), .load_val(if_b.load_val),
        .cnt(if_b.cnt), .tc(if_b.tc), .ovf(if_b.ovf)
    );

    param_counter #(
        .WIDTH(4), .MAX_VAL(9), .MODE(MODE_SAT), .PRESCALE(2)
    ) u_c (
        .clk(clk), .reset(reset),
        .enable(if_c.enable), .up_dn(if_c.up_dn),
        .load(if_c.load), .load_val(if_c.load_val),
        .cnt(if_c.cnt), .tc(if_c.tc), .ovf(if_c.ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count enabled cycles; every pre-th one moves the count.
    function automatic mst_t mnext(mst_t s, int maxv, bit sat, int pre,
                                   bit en, bit ud, bit ld, int lv);
        mst_t n;
        n    = s;
        n.tc = 1'b0;
        if (ld) begin
            n.cnt = (lv > maxv) ? maxv : lv;
            n.psc = 0;
            n.ovf = 1'b0;
        end else if (en) begin
            n.psc = s.psc + 1;
            if (n.psc == pre) begin
                n.psc = 0;
                if (ud && s.cnt == maxv) begin
                    n.cnt = sat ? maxv : 0;
                    n.tc  = 1'b1;
                    n.ovf = 1'b1;
                end else if (!ud && s.cnt == 0) begin
                    n.cnt = sat ? 0 : maxv;
                    n.tc  = 1'b1;
                    n.ovf = 1'b1;
                end else begin
                    n.cnt = ud ? s.cnt + 1 : s.cnt - 1;
                end
            end
        end
        return n;
    endfunction

    function automatic void chk(string nm, int c, bit t, bit o, mst_t e);
        tests++;
        if (c != e.cnt || t != e.tc || o != e.ovf) begin
            errors++;
            $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     nm, c, t, o, e.cnt, e.tc, e.ovf);
        end
    endfunction

    task automatic drive(bit en, bit ud, bit ld, int lva, int lvbc);
        @(negedge clk);
        if_a.enable = en;  if_a.up_dn = ud;  if_a.load = ld;
        if_b.enable = en;  if_b.up_dn = ud;  if_b.load = ld;
        if_c.enable = en;  if_c.up_dn = ud;  if_c.load = ld;
        if_a.load_val = 8'(lva);
        if_b.load_val = 4'(lvbc);
        if_c.load_val = 4'(lvbc);
        ma = mnext(ma, 255, 1'b0, 1, en, ud, ld, lva & 255);
        mb = mnext(mb, 9, 1'b0, 3, en, ud, ld, lvbc & 15);
        mc = mnext(mc, 9, 1'b1, 2, en, ud, ld, lvbc & 15);
        qa.push_back(ma);
        qb.push_back(mb);
        qc.push_back(mc);
    endtask

    // Monitor: outputs are valid every cycle, compared 1 time unit after the edge.
    initial begin
        mst_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("A_w8_wrap_p1", int'(if_a.cnt), if_a.tc, if_a.ovf, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("B_max9_wrap_p3", int'(if_b.cnt), if_b.tc, if_b.ovf, e);
            end
            if (qc.size() > 0) begin
                e = qc.pop_front();
                chk("C_max9_sat_p2", int'(if_c.cnt), if_c.tc, if_c.ovf, e);
            end
        end
    end

    initial begin
        zero_st = '{cnt: 0, psc: 0, tc: 1'b0, ovf: 1'b0};
        ma = zero_st;
        mb = zero_st;
        mc = zero_st;
        reset = 1'b1;
        if_a.enable = 0; if_a.up_dn = 0; if_a.load = 0; if_a.load_val = '0;
        if_b.enable = 0; if_b.up_dn = 0; if_b.load = 0; if_b.load_val = '0;
        if_c.enable = 0; if_c.up_dn = 0; if_c.load = 0; if_c.load_val = '0;

        #56;
        chk("reset_A", int'(if_a.cnt), if_a.tc, if_a.ovf, zero_st);
        chk("reset_B", int'(if_b.cnt), if_b.tc, if_b.ovf, zero_st);
        chk("reset_C", int'(if_c.cnt), if_c.tc, if_c.ovf, zero_st);
        reset = 1'b0;

        // Count up across the full 8-bit range and the 0..9 decade.
        for (int i = 0; i < 300; i++) drive(1, 1, 0, 0, 0);

        // Saturating count down from 2 into the floor.
        drive(0, 0, 1, 2, 2);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 0);

        // Load above MAX_VAL with enable low clamps and clears ovf.
        drive(0, 1, 1, 15, 15);
        drive(0, 1, 0, 0, 0);

        // Load coinciding with a boundary step: load wins, no tc.
        drive(1, 1, 1, 9, 9);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 9, 9);
        drive(1, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3, 0) != 0, 1'($urandom),
                  $urandom_range(15, 0) == 0,
                  int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));
        end

        // Asynchronous reset between edges with B at cnt=5, psc=1.
        drive(0, 1, 1, 5, 5);
        drive(1, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        ma = zero_st;
        mb = zero_st;
        mc = zero_st;
        chk("async_rst_A", int'(if_a.cnt), if_a.tc, if_a.ovf, zero_st);
        chk("async_rst_B", int'(if_b.cnt), if_b.tc, if_b.ovf, zero_st);
        chk("async_rst_C", int'(if_c.cnt), if_c.tc, if_c.ovf, zero_st);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, 0);

        @(posedge clk);
        #2;
        tests++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, expected 0",
                     qa.size() + qb.size() + qc.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
